// File: rtl/bsg_axil_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bsg_axil_rr_arbiter
// Purpose  : Round-robin arbiter that shares one AXI4-Lite slave port among
//            num_masters_p AXI4-Lite masters. Read and write channels are
//            arbitrated independently, with one outstanding transaction per
//            channel. Responses are routed only to the granted master.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_axil_rr_arbiter #(
    parameter int num_masters_p = 2,
    parameter int addr_width_p  = 32,
    parameter int data_width_p  = 32
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,

    // Upstream masters (master 0 in the LSBs of every packed field)
    input  logic [num_masters_p*addr_width_p-1:0]      m_awaddr_i,
    input  logic [num_masters_p*3-1:0]                 m_awprot_i,
    input  logic [num_masters_p-1:0]                   m_awvalid_i,
    output logic [num_masters_p-1:0]                   m_awready_o,

    input  logic [num_masters_p*data_width_p-1:0]      m_wdata_i,
    input  logic [num_masters_p*(data_width_p/8)-1:0]  m_wstrb_i,
    input  logic [num_masters_p-1:0]                   m_wvalid_i,
    output logic [num_masters_p-1:0]                   m_wready_o,

    output logic [num_masters_p*2-1:0]                 m_bresp_o,
    output logic [num_masters_p-1:0]                   m_bvalid_o,
    input  logic [num_masters_p-1:0]                   m_bready_i,

    input  logic [num_masters_p*addr_width_p-1:0]      m_araddr_i,
    input  logic [num_masters_p*3-1:0]                 m_arprot_i,
    input  logic [num_masters_p-1:0]                   m_arvalid_i,
    output logic [num_masters_p-1:0]                   m_arready_o,

    output logic [num_masters_p*data_width_p-1:0]      m_rdata_o,
    output logic [num_masters_p*2-1:0]                 m_rresp_o,
    output logic [num_masters_p-1:0]                   m_rvalid_o,
    input  logic [num_masters_p-1:0]                   m_rready_i,

    // Downstream slave
    output logic [addr_width_p-1:0]                    s_awaddr_o,
    output logic [2:0]                                 s_awprot_o,
    output logic                                       s_awvalid_o,
    input  logic                                       s_awready_i,

    output logic [data_width_p-1:0]                    s_wdata_o,
    output logic [(data_width_p/8)-1:0]                s_wstrb_o,
    output logic                                       s_wvalid_o,
    input  logic                                       s_wready_i,

    input  logic [1:0]                                 s_bresp_i,
    input  logic                                       s_bvalid_i,
    output logic                                       s_bready_o,

    output logic [addr_width_p-1:0]                    s_araddr_o,
    output logic [2:0]                                 s_arprot_o,
    output logic                                       s_arvalid_o,
    input  logic                                       s_arready_i,

    input  logic [data_width_p-1:0]                    s_rdata_i,
    input  logic [1:0]                                 s_rresp_i,
    input  logic                                       s_rvalid_i,
    output logic                                       s_rready_o
);

    localparam int STRB_W = data_width_p / 8;
    localparam int PTR_W  = $clog2(num_masters_p);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_FWD  = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_FWD  = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    // First requester at or after ptr, wrapping modulo num_masters_p
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [num_masters_p-1:0] req,
        input logic [PTR_W-1:0]         ptr
    );
        logic [PTR_W-1:0] pick;
        logic [PTR_W:0]   sum;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int off = 0; off < num_masters_p; off++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(num_masters_p)) begin
                sum = sum - (PTR_W+1)'(num_masters_p);
            end
            if (!found && req[sum[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[PTR_W-1:0];
            end
        end
        return pick;
    endfunction

    // Successor of a grant index, wrapping modulo num_masters_p
    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] gnt);
        if (gnt == PTR_W'(num_masters_p - 1)) begin
            return '0;
        end
        return gnt + PTR_W'(1);
    endfunction

    logic [1:0]       wr_state_q, wr_state_d;
    logic [PTR_W-1:0] wr_gnt_q,   wr_gnt_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic             aw_done_q,  aw_done_d;
    logic             w_done_q,   w_done_d;

    logic [1:0]       rd_state_q, rd_state_d;
    logic [PTR_W-1:0] rd_gnt_q,   rd_gnt_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;

    // A master is only eligible for writing once both AW and W are offered
    logic [num_masters_p-1:0] wr_req;
    assign wr_req = m_awvalid_i & m_wvalid_i;

    // Write-channel next-state logic
    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        wr_ptr_d   = wr_ptr_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            W_IDLE: begin
                if (|wr_req) begin
                    wr_gnt_d   = rr_pick(wr_req, wr_ptr_q);
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_FWD;
                end
            end
            W_FWD: begin
                aw_done_d = aw_done_q | (s_awvalid_o & s_awready_i);
                w_done_d  = w_done_q  | (s_wvalid_o  & s_wready_i);
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bvalid_i && s_bready_o) begin
                    wr_ptr_d   = rr_next(wr_gnt_q);
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read-channel next-state logic
    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
        rd_ptr_d   = rd_ptr_q;
        case (rd_state_q)
            R_IDLE: begin
                if (|m_arvalid_i) begin
                    rd_gnt_d   = rr_pick(m_arvalid_i, rd_ptr_q);
                    rd_state_d = R_FWD;
                end
            end
            R_FWD: begin
                if (s_arready_i) begin
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_rvalid_i && s_rready_o) begin
                    rd_ptr_d   = rr_next(rd_gnt_q);
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // State registers for both channels; reset wins over any transition
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_state_q <= W_IDLE;
            wr_gnt_q   <= '0;
            wr_ptr_q   <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rd_state_q <= R_IDLE;
            rd_gnt_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_gnt_q   <= wr_gnt_d;
            wr_ptr_q   <= wr_ptr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rd_state_q <= rd_state_d;
            rd_gnt_q   <= rd_gnt_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Write-channel steering: fields are zero outside the phase that uses them
    always_comb begin
        s_awvalid_o = 1'b0;
        s_awaddr_o  = '0;
        s_awprot_o  = '0;
        s_wvalid_o  = 1'b0;
        s_wdata_o   = '0;
        s_wstrb_o   = '0;
        s_bready_o  = 1'b0;
        m_awready_o = '0;
        m_wready_o  = '0;
        m_bvalid_o  = '0;
        m_bresp_o   = '0;
        if (wr_state_q == W_FWD) begin
            s_awvalid_o           = ~aw_done_q;
            s_awaddr_o            = m_awaddr_i[wr_gnt_q*addr_width_p +: addr_width_p];
            s_awprot_o            = m_awprot_i[wr_gnt_q*3 +: 3];
            s_wvalid_o            = ~w_done_q;
            s_wdata_o             = m_wdata_i[wr_gnt_q*data_width_p +: data_width_p];
            s_wstrb_o             = m_wstrb_i[wr_gnt_q*STRB_W +: STRB_W];
            m_awready_o[wr_gnt_q] = s_awready_i & ~aw_done_q;
            m_wready_o[wr_gnt_q]  = s_wready_i & ~w_done_q;
        end
        if (wr_state_q == W_RESP) begin
            s_bready_o                 = m_bready_i[wr_gnt_q];
            m_bvalid_o[wr_gnt_q]       = s_bvalid_i;
            m_bresp_o[wr_gnt_q*2 +: 2] = s_bresp_i;
        end
    end

    // Read-channel steering: fields are zero outside the phase that uses them
    always_comb begin
        s_arvalid_o = 1'b0;
        s_araddr_o  = '0;
        s_arprot_o  = '0;
        s_rready_o  = 1'b0;
        m_arready_o = '0;
        m_rvalid_o  = '0;
        m_rdata_o   = '0;
        m_rresp_o   = '0;
        if (rd_state_q == R_FWD) begin
            s_arvalid_o           = 1'b1;
            s_araddr_o            = m_araddr_i[rd_gnt_q*addr_width_p +: addr_width_p];
            s_arprot_o            = m_arprot_i[rd_gnt_q*3 +: 3];
            m_arready_o[rd_gnt_q] = s_arready_i;
        end
        if (rd_state_q == R_RESP) begin
            s_rready_o                                   = m_rready_i[rd_gnt_q];
            m_rvalid_o[rd_gnt_q]                         = s_rvalid_i;
            m_rdata_o[rd_gnt_q*data_width_p +: data_width_p] = s_rdata_i;
            m_rresp_o[rd_gnt_q*2 +: 2]                   = s_rresp_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_axil_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_axil_rr_arbiter
// Purpose  : Directed bench for bsg_axil_rr_arbiter (2 masters, 32-bit).
//            Per-cycle write vectors from a table, then hand sequences for
//            split AW/W, concurrent read/write, R backpressure and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_axil_rr_arbiter;

    logic        clk_i;
    logic        reset_i;
    logic [63:0] m_awaddr_i;
    logic [5:0]  m_awprot_i;
    logic [1:0]  m_awvalid_i;
    logic [1:0]  m_awready_o;
    logic [63:0] m_wdata_i;
    logic [7:0]  m_wstrb_i;
    logic [1:0]  m_wvalid_i;
    logic [1:0]  m_wready_o;
    logic [3:0]  m_bresp_o;
    logic [1:0]  m_bvalid_o;
    logic [1:0]  m_bready_i;
    logic [63:0] m_araddr_i;
    logic [5:0]  m_arprot_i;
    logic [1:0]  m_arvalid_i;
    logic [1:0]  m_arready_o;
    logic [63:0] m_rdata_o;
    logic [3:0]  m_rresp_o;
    logic [1:0]  m_rvalid_o;
    logic [1:0]  m_rready_i;
    logic [31:0] s_awaddr_o;
    logic [2:0]  s_awprot_o;
    logic        s_awvalid_o;
    logic        s_awready_i;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_wstrb_o;
    logic        s_wvalid_o;
    logic        s_wready_i;
    logic [1:0]  s_bresp_i;
    logic        s_bvalid_i;
    logic        s_bready_o;
    logic [31:0] s_araddr_o;
    logic [2:0]  s_arprot_o;
    logic        s_arvalid_o;
    logic        s_arready_i;
    logic [31:0] s_rdata_i;
    logic [1:0]  s_rresp_i;
    logic        s_rvalid_i;
    logic        s_rready_o;

    bsg_axil_rr_arbiter #(
        .num_masters_p(2),
        .addr_width_p (32),
        .data_width_p (32)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .m_awaddr_i  (m_awaddr_i),
        .m_awprot_i  (m_awprot_i),
        .m_awvalid_i (m_awvalid_i),
        .m_awready_o (m_awready_o),
        .m_wdata_i   (m_wdata_i),
        .m_wstrb_i   (m_wstrb_i),
        .m_wvalid_i  (m_wvalid_i),
        .m_wready_o  (m_wready_o),
        .m_bresp_o   (m_bresp_o),
        .m_bvalid_o  (m_bvalid_o),
        .m_bready_i  (m_bready_i),
        .m_araddr_i  (m_araddr_i),
        .m_arprot_i  (m_arprot_i),
        .m_arvalid_i (m_arvalid_i),
        .m_arready_o (m_arready_o),
        .m_rdata_o   (m_rdata_o),
        .m_rresp_o   (m_rresp_o),
        .m_rvalid_o  (m_rvalid_o),
        .m_rready_i  (m_rready_i),
        .s_awaddr_o  (s_awaddr_o),
        .s_awprot_o  (s_awprot_o),
        .s_awvalid_o (s_awvalid_o),
        .s_awready_i (s_awready_i),
        .s_wdata_o   (s_wdata_o),
        .s_wstrb_o   (s_wstrb_o),
        .s_wvalid_o  (s_wvalid_o),
        .s_wready_i  (s_wready_i),
        .s_bresp_i   (s_bresp_i),
        .s_bvalid_i  (s_bvalid_i),
        .s_bready_o  (s_bready_o),
        .s_araddr_o  (s_araddr_o),
        .s_arprot_o  (s_arprot_o),
        .s_arvalid_o (s_arvalid_o),
        .s_arready_i (s_arready_i),
        .s_rdata_i   (s_rdata_i),
        .s_rresp_i   (s_rresp_i),
        .s_rvalid_i  (s_rvalid_i),
        .s_rready_o  (s_rready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One write-channel cycle: inputs applied, combinational outputs expected
    typedef struct {
        logic        rst;
        logic [1:0]  awv, wv;
        logic        sawr, swr, sbv;
        logic [1:0]  sbresp;
        logic [1:0]  br;
        logic        e_sawv, e_swv;
        logic [1:0]  e_mawr, e_mwr, e_mbv;
        logic        e_sbr;
        logic [3:0]  e_bresp;
        logic [31:0] e_addr, e_data;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic [1:0] awv, input logic [1:0] wv,
        input logic sawr, input logic swr, input logic sbv, input logic [1:0] sbresp,
        input logic [1:0] br, input logic e_sawv, input logic e_swv,
        input logic [1:0] e_mawr, input logic [1:0] e_mwr, input logic [1:0] e_mbv,
        input logic e_sbr, input logic [3:0] e_bresp,
        input logic [31:0] e_addr, input logic [31:0] e_data);
        vec_t v;
        v.rst = rst; v.awv = awv; v.wv = wv; v.sawr = sawr; v.swr = swr;
        v.sbv = sbv; v.sbresp = sbresp; v.br = br; v.e_sawv = e_sawv;
        v.e_swv = e_swv; v.e_mawr = e_mawr; v.e_mwr = e_mwr; v.e_mbv = e_mbv;
        v.e_sbr = e_sbr; v.e_bresp = e_bresp; v.e_addr = e_addr; v.e_data = e_data;
        return v;
    endfunction

    task automatic zero_inputs();
        m_awvalid_i = '0; m_wvalid_i = '0; m_bready_i = '0;
        m_arvalid_i = '0; m_rready_i = '0;
        s_awready_i = 1'b0; s_wready_i = 1'b0; s_bvalid_i = 1'b0; s_bresp_i = '0;
        s_arready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0; s_rresp_i = '0;
    endtask

    vec_t        tbl[$];
    logic [31:0] waddr [2];
    logic [31:0] wdata [2];

    initial begin
        waddr[0] = 32'h10; waddr[1] = 32'h24;
        wdata[0] = 32'hDEADBEEF; wdata[1] = 32'hCAFEF00D;

        // Single write from master 0, slave always ready
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 1, 0, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 1, 0, 2'b00, 2'b01, 1, 1, 2'b01, 2'b01, 2'b00, 0, 4'h0, 32'h10, 32'hDEADBEEF));
        tbl.push_back(mk(0, 2'b00, 2'b00, 1, 1, 1, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 2'b01, 1, 4'h0, 32'h0, 32'h0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 1, 1, 0, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 32'h0, 32'h0));
        // Reset idle cycle so contention starts from pointer 0
        tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 32'h0, 32'h0));
        // Contention: both masters keep requesting; grants alternate 0,1,...
        for (int k = 0; k < 8; k++) begin
            int          g;
            logic [1:0]  oh;
            logic [1:0]  rsp;
            logic [3:0]  erp;
            g   = k % 2;
            oh  = (g == 0) ? 2'b01 : 2'b10;
            rsp = (g == 0) ? 2'b01 : 2'b10;
            erp = (g == 0) ? 4'b0001 : 4'b1000;
            tbl.push_back(mk(0, 2'b11, 2'b11, 1, 1, 1, rsp, 2'b11, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 32'h0, 32'h0));
            tbl.push_back(mk(0, 2'b11, 2'b11, 1, 1, 1, rsp, 2'b11, 1, 1, oh, oh, 2'b00, 0, 4'h0, waddr[g], wdata[g]));
            tbl.push_back(mk(0, 2'b11, 2'b11, 1, 1, 1, rsp, 2'b11, 0, 0, 2'b00, 2'b00, oh, 1, erp, 32'h0, 32'h0));
        end

        m_awaddr_i = {32'h24, 32'h10};
        m_awprot_i = {3'b010, 3'b001};
        m_wdata_i  = {32'hCAFEF00D, 32'hDEADBEEF};
        m_wstrb_i  = {4'h3, 4'hF};
        m_araddr_i = {32'h20, 32'h30};
        m_arprot_i = {3'b100, 3'b000};
        zero_inputs();
        reset_i = 1'b1;

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst.sawv", s_awvalid_o, 0);
        chk("rst.swv", s_wvalid_o, 0);
        chk("rst.sarv", s_arvalid_o, 0);
        chk("rst.mawr", m_awready_o, 0);
        chk("rst.awaddr", s_awaddr_o, 0);
        chk("rst.rdata", m_rdata_o, 0);

        // Table-driven write vectors
        foreach (tbl[i]) begin
            @(negedge clk_i);
            reset_i     = tbl[i].rst;
            m_awvalid_i = tbl[i].awv;
            m_wvalid_i  = tbl[i].wv;
            s_awready_i = tbl[i].sawr;
            s_wready_i  = tbl[i].swr;
            s_bvalid_i  = tbl[i].sbv;
            s_bresp_i   = tbl[i].sbresp;
            m_bready_i  = tbl[i].br;
            #1;
            chk($sformatf("v%0d.sawv", i), s_awvalid_o, tbl[i].e_sawv);
            chk($sformatf("v%0d.swv", i), s_wvalid_o, tbl[i].e_swv);
            chk($sformatf("v%0d.mawr", i), m_awready_o, tbl[i].e_mawr);
            chk($sformatf("v%0d.mwr", i), m_wready_o, tbl[i].e_mwr);
            chk($sformatf("v%0d.mbv", i), m_bvalid_o, tbl[i].e_mbv);
            chk($sformatf("v%0d.sbr", i), s_bready_o, tbl[i].e_sbr);
            chk($sformatf("v%0d.bresp", i), m_bresp_o, tbl[i].e_bresp);
            chk($sformatf("v%0d.awaddr", i), s_awaddr_o, tbl[i].e_addr);
            chk($sformatf("v%0d.wdata", i), s_wdata_o, tbl[i].e_data);
        end

        // Split AW/W: AW accepted in cycle 1, W in cycle 4 (wr_ptr is 0)
        @(negedge clk_i); zero_inputs();
        m_awvalid_i = 2'b01; m_wvalid_i = 2'b01; s_awready_i = 1; m_bready_i = 2'b01;
        #1; chk("split.c0.sawv", s_awvalid_o, 0);
        @(negedge clk_i); #1;
        chk("split.c1.sawv", s_awvalid_o, 1);
        chk("split.c1.mawr", m_awready_o, 2'b01);
        chk("split.c1.mwr", m_wready_o, 2'b00);
        chk("split.c1.wstrb", s_wstrb_o, 4'hF);
        chk("split.c1.awprot", s_awprot_o, 3'b001);
        for (int c = 2; c < 4; c++) begin
            @(negedge clk_i); m_awvalid_i = 2'b00; #1;
            chk($sformatf("split.c%0d.sawv", c), s_awvalid_o, 0);
            chk($sformatf("split.c%0d.swv", c), s_wvalid_o, 1);
            chk($sformatf("split.c%0d.mawr", c), m_awready_o, 2'b00);
        end
        @(negedge clk_i); s_wready_i = 1; #1;
        chk("split.c4.swv", s_wvalid_o, 1);
        chk("split.c4.mwr", m_wready_o, 2'b01);
        chk("split.c4.wdata", s_wdata_o, 32'hDEADBEEF);
        @(negedge clk_i); m_wvalid_i = 2'b00; #1;
        chk("split.c5.swv", s_wvalid_o, 0);
        chk("split.c5.sbr", s_bready_o, 1);
        chk("split.c5.mbv", m_bvalid_o, 2'b00);
        @(negedge clk_i); s_bvalid_i = 1; #1;
        chk("split.c6.mbv", m_bvalid_o, 2'b01);

        // Concurrent read (master 1, 0x20) and write (master 0)
        @(negedge clk_i); zero_inputs();
        m_awvalid_i = 2'b01; m_wvalid_i = 2'b01; s_awready_i = 1; s_wready_i = 1;
        m_arvalid_i = 2'b10; s_arready_i = 1; m_bready_i = 2'b01;
        #1; chk("conc.c0.sarv", s_arvalid_o, 0);
        @(negedge clk_i); #1;
        chk("conc.c1.sarv", s_arvalid_o, 1);
        chk("conc.c1.araddr", s_araddr_o, 32'h20);
        chk("conc.c1.arprot", s_arprot_o, 3'b100);
        chk("conc.c1.marr", m_arready_o, 2'b10);
        chk("conc.c1.mawr", m_awready_o, 2'b01);
        @(negedge clk_i);
        m_awvalid_i = 0; m_wvalid_i = 0; m_arvalid_i = 0;
        s_rvalid_i = 1; s_rdata_i = 32'h12345678; s_rresp_i = 2'b10; m_rready_i = 2'b11;
        s_bvalid_i = 1;
        #1;
        chk("conc.c2.mrv", m_rvalid_o, 2'b10);
        chk("conc.c2.rdata", m_rdata_o, {32'h12345678, 32'h0});
        chk("conc.c2.rresp", m_rresp_o, 4'b1000);
        chk("conc.c2.srr", s_rready_o, 1);
        chk("conc.c2.mbv", m_bvalid_o, 2'b01);

        // Backpressure on R from master 0 (rd_ptr is 0)
        @(negedge clk_i); zero_inputs();
        m_arvalid_i = 2'b01; s_arready_i = 1;
        #1; chk("bp.c0.sarv", s_arvalid_o, 0);
        @(negedge clk_i); #1;
        chk("bp.c1.araddr", s_araddr_o, 32'h30);
        chk("bp.c1.marr", m_arready_o, 2'b01);
        for (int c = 2; c < 7; c++) begin
            @(negedge clk_i);
            m_arvalid_i = 2'b10; s_rvalid_i = 1; s_rdata_i = 32'hA5A5A5A5; m_rready_i = 2'b10;
            #1;
            chk($sformatf("bp.c%0d.srr", c), s_rready_o, 0);
            chk($sformatf("bp.c%0d.mrv", c), m_rvalid_o, 2'b01);
            chk($sformatf("bp.c%0d.sarv", c), s_arvalid_o, 0);
            chk($sformatf("bp.c%0d.rdata", c), m_rdata_o, {32'h0, 32'hA5A5A5A5});
        end
        @(negedge clk_i); m_arvalid_i = 2'b11; m_rready_i = 2'b11; #1;
        chk("bp.c7.srr", s_rready_o, 1);
        @(negedge clk_i); s_rvalid_i = 0; #1;
        chk("bp.c8.sarv", s_arvalid_o, 0);
        @(negedge clk_i); #1;
        chk("bp.c9.marr", m_arready_o, 2'b10);
        chk("bp.c9.araddr", s_araddr_o, 32'h20);
        @(negedge clk_i); m_arvalid_i = 0; s_rvalid_i = 1; #1;
        chk("bp.c10.mrv", m_rvalid_o, 2'b10);

        // Reset in W_RESP while a B handshake is offered (wr_ptr is 1)
        @(negedge clk_i); zero_inputs();
        m_awvalid_i = 2'b01; m_wvalid_i = 2'b01; s_awready_i = 1; s_wready_i = 1; m_bready_i = 2'b11;
        @(negedge clk_i); #1;
        chk("rmid.fwd.mawr", m_awready_o, 2'b01);
        @(negedge clk_i); m_awvalid_i = 0; m_wvalid_i = 0; s_bvalid_i = 1; reset_i = 1; #1;
        chk("rmid.resp.sbr", s_bready_o, 1);
        @(negedge clk_i); reset_i = 0; s_bvalid_i = 0; #1;
        chk("rmid.post.sbr", s_bready_o, 0);
        chk("rmid.post.mbv", m_bvalid_o, 0);
        chk("rmid.post.sawv", s_awvalid_o, 0);
        chk("rmid.post.swv", s_wvalid_o, 0);
        chk("rmid.post.awaddr", s_awaddr_o, 0);
        chk("rmid.post.bresp", m_bresp_o, 0);
        m_awvalid_i = 2'b11; m_wvalid_i = 2'b11;
        @(negedge clk_i); #1;
        chk("rmid.g0.mawr", m_awready_o, 2'b01);
        @(negedge clk_i); s_bvalid_i = 1; #1;
        chk("rmid.g0.mbv", m_bvalid_o, 2'b01);
        @(negedge clk_i); s_bvalid_i = 0; m_awvalid_i = 2'b10; m_wvalid_i = 2'b10;
        @(negedge clk_i); #1;
        chk("rmid.g1.mawr", m_awready_o, 2'b10);
        chk("rmid.g1.awaddr", s_awaddr_o, 32'h24);
        chk("rmid.g1.wdata", s_wdata_o, 32'hCAFEF00D);
        @(negedge clk_i); m_awvalid_i = 0; m_wvalid_i = 0; s_bvalid_i = 1; #1;
        chk("rmid.g1.mbv", m_bvalid_o, 2'b10);
        @(negedge clk_i); zero_inputs();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsg_axil_rr_arbiter.md
# bsg_axil_rr_arbiter

Round-robin arbiter that shares one AXI4-Lite slave port among `num_masters_p` AXI4-Lite masters, e.g. the GP0/GP1/GP2 host ports of the Zynq cosim shell converging onto a single control-register block. Read and write channels are arbitrated independently. Each channel allows one outstanding transaction at a time. Responses are routed back to the granted master only.

## Interface
- `num_masters_p`, default 2: number of upstream masters (≥2).
- `addr_width_p`, default 32: AXI-Lite address width.
- `data_width_p`, default 32: AXI-Lite data width; strobe width is `data_width_p/8`.
- clk_i  in  1  single clock for all ports.
- reset_i  in  1  synchronous, active-high reset.
- `m_aw{addr,prot,valid}_i`, `m_awready_o`  in/out  `num_masters_p`×{addr_width_p,3,1}, `num_masters_p`  per-master write address, packed arrays with master 0 in the LSBs.
- `m_w{data,strb,valid}_i`, `m_wready_o`  in/out  per-master write data.
- `m_b{resp,valid}_o`, `m_bready_i`  out/in  per-master write response.
- `m_ar{addr,prot,valid}_i`, `m_arready_o`  in/out  per-master read address.
- `m_r{data,resp,valid}_o`, `m_rready_i`  out/in  per-master read data.
- `s_aw*_o/_i`, `s_w*_o/_i`, `s_b*_i/_o`, `s_ar*_o/_i`, `s_r*_i/_o`  single downstream AXI-Lite master interface with identical fields.

## Operation
The write FSM has three states: W_IDLE, W_FWD and W_RESP.
- **W_IDLE**
  - A write request for master i is `m_awvalid_i[i] & m_wvalid_i[i]`.
  - If any request is present, the arbiter picks the first requester at or after `wr_ptr`, searching upward and wrapping modulo `num_masters_p`.
  - The grant index is registered in `wr_gnt`, and `aw_done` and `w_done` are cleared.
  - The FSM then moves to W_FWD.
- **W_FWD**
  - `s_awvalid_o = ~aw_done`, carrying the granted master's AW fields.
  - `s_wvalid_o = ~w_done`, carrying the granted master's W fields.
  - `m_awready_o[wr_gnt] = s_awready_i & ~aw_done`, and likewise for W. All other masters see ready=0.
  - Each handshake sets its done flag. AW and W may complete in either order or in the same cycle.
  - When both are done, the FSM moves to W_RESP.
- **W_RESP**
  - `s_bready_o = m_bready_i[wr_gnt]`.
  - `m_bvalid_o[wr_gnt] = s_bvalid_i` and `m_bresp_o[wr_gnt] = s_bresp_i`.
  - On the B handshake, `wr_ptr` becomes `(wr_gnt+1) mod num_masters_p` and the FSM returns to W_IDLE.

The read FSM has three states: R_IDLE, R_FWD and R_RESP. It mirrors the write FSM, with these differences:
- The request is `m_arvalid_i[i]` alone.
- R_FWD forwards AR and moves to R_RESP on the `s_arready_i` handshake.
- R_RESP routes R back to the granted master and advances `rd_ptr` on the R handshake.

Behaviour common to both channels:
- Ungranted masters always see every ready and every valid at 0. Data and resp outputs to ungranted masters are 0.
- The read and write FSMs are fully independent. The same master may hold a read grant and a write grant simultaneously.
- Once granted, AW/W/AR fields are sampled combinationally from the master. AXI requires masters to hold them stable until the handshake.
- There is no timeout and no error generation. Slave bresp/rresp values are passed through unchanged.

## Timing
- Reset values:
  - Both FSMs in IDLE; `wr_ptr = rd_ptr = 0`.
  - `aw_done = w_done = 0`.
  - All valid and ready outputs 0; all data, addr and resp outputs 0.
- Arbitration latency:
  - A request sampled in IDLE at edge t causes slave `*valid` to assert in cycle t+1.
  - The minimum write takes 3 cycles: IDLE, FWD with AW and W accepted together, and RESP with B ready immediately.
  - The minimum read takes 3 cycles.
- Throughput: at most one transaction per channel per 3 cycles. There is no back-to-back bypass from RESP to FWD.
- Combinational paths:
  - `s_*ready_i` to `m_*ready_o`.
  - `s_*valid_i` to `m_*valid_o`.
  - `m_*ready_i` to `s_*ready_o`.
- Fairness: each requester waits at most `num_masters_p-1` transactions of that channel before being granted.
- If `m_awvalid` rises before `m_wvalid`, the master is not eligible until both are high. No partial grant is issued.
- reset_i asserted mid-transaction:
  - The next cycle returns to the reset values, and any in-flight slave transaction is abandoned.
  - The slave shares `reset_i`, so both sides are reset together.
- `reset_i` has priority over all transitions in the same cycle.

## Test plan
- **Single write:**
  - Stimulus: master 0 writes `addr=0x10`, `data=0xDEADBEEF`, `strb=0xF`; the slave is always ready.
  - Response: `s_awaddr_o=0x10` in cycle 1; `m_bvalid_o[0]` with `bresp=0` in cycle 2; master 1 sees no valid or ready at any time.
- **Contention:**
  - Stimulus: masters 0 and 1 each issue 4 writes simultaneously.
  - Response: grant order is 0,1,0,1,0,1,0,1; each `bvalid` goes only to the issuing master; slave receives the data in matching order.
- **Split AW/W:**
  - Stimulus: the slave accepts AW in cycle 1 and W in cycle 4.
  - Response: `s_awvalid_o` drops after cycle 1; `s_wvalid_o` stays high through cycle 4; FSM enters W_RESP in cycle 5; no duplicate AW is issued.
- **Concurrent read and write:**
  - Stimulus: master 1 reads `0x20` while master 0 writes.
  - Response: both complete independently; `rdata=0x12345678` from the slave appears only on `m_rdata_o[1]`.
- **Backpressure:**
  - Stimulus: `m_rready_i[0]=0` for 5 cycles while `s_rvalid_i=1`.
  - Response: `s_rready_o` stays 0 for those 5 cycles; a new AR from master 1 is not forwarded until the R handshake completes; `rd_ptr` then becomes 1.
- **Reset mid-operation:**
  - Stimulus: assert `reset_i` in W_RESP, then deassert.
  - Response: all outputs are 0 the next cycle; `wr_ptr=0`; a subsequent write from master 1 is granted normally.
